// File: rtl/in_deser_cell.sv
// Serial-to-parallel input deserializer with framed word assembly,
// a single-entry output holding register and sticky overflow/sync flags.
module in_deser_cell #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 0
) (
   input  logic             IQC,
   input  logic             QRT,
   input  logic             IQZ,
   input  logic             EN,
   input  logic             FRAME,
   input  logic             DREADY,
   input  logic             ERR_CLR,
   output logic [WIDTH-1:0] DOUT,
   output logic             DVALID,
   output logic             OVF,
   output logic             SYNC_ERR
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic [CW-1:0]    pos;
   logic [CW-1:0]    idx;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] word;
   logic             start;
   logic             step;
   logic             done;
   logic             sync_set;
   logic             ovf_set;
   logic             load;

   always_ff @(posedge IQC) begin
      if (QRT) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      start     = EN & FRAME;
      step      = EN & ~FRAME & (state == SHIFT);
      sync_set  = start & (state == SHIFT);
      done      = step & (cnt == LAST);
      pos       = start ? '0 : cnt;
      idx       = (MSB_FIRST != 0) ? LAST - pos : pos;
      // A start bit always begins from a clean word so no partial data leaks
      word      = start ? '0 : sreg;
      for (int i = 0; i < WIDTH; i++) begin
         if (idx == CW'(i)) word[i] = IQZ;
      end
      if (start) begin
         state_nxt = SHIFT;
         cnt_nxt   = CW'(1);
      end else if (done) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else if (step) begin
         cnt_nxt   = cnt + CW'(1);
      end
      load    = done & (~DVALID | DREADY);
      ovf_set = done & DVALID & ~DREADY;
   end

   always_ff @(posedge IQC) begin
      if (QRT) begin
         cnt      <= '0;
         sreg     <= '0;
         DOUT     <= '0;
         DVALID   <= 1'b0;
         OVF      <= 1'b0;
         SYNC_ERR <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (start | step) sreg <= word;
         if (load) begin
            DOUT   <= word;
            DVALID <= 1'b1;
         end else if (DVALID & DREADY) begin
            DVALID <= 1'b0;
         end
         OVF      <= ovf_set | (OVF & ~ERR_CLR);
         SYNC_ERR <= sync_set | (SYNC_ERR & ~ERR_CLR);
      end
   end

endmodule

// File: doc/in_deser_cell.md
IN_DESER_CELL -- requirements
Module: in_deser_cell

Interface
REQ-001 Parameter: WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 Parameter: MSB_FIRST, default 0, bit order; 0 = first serial bit to DOUT[0], 1 = first serial bit to DOUT[WIDTH-1].
REQ-003 Port: IQC  input  1  clock; single clock domain, all state updates on posedge IQC.
REQ-004 Port: QRT  input  1  reset; synchronous, active-high.
REQ-005 Port: IQZ  input  1  serial data from the upstream input register cell.
REQ-006 Port: EN  input  1  sample enable; IQZ and FRAME are qualified only when EN=1.
REQ-007 Port: FRAME  input  1  start-of-word marker; high on the cycle carrying the first bit of a word.
REQ-008 Port: DREADY  input  1  consumer accepts DOUT when DVALID=1.
REQ-009 Port: ERR_CLR  input  1  clears sticky error flags.
REQ-010 Port: DOUT  output  WIDTH  assembled parallel word.
REQ-011 Port: DVALID  output  1  DOUT holds an unconsumed word.
REQ-012 Port: OVF  output  1  sticky; a completed word was dropped.
REQ-013 Port: SYNC_ERR  output  1  sticky; FRAME arrived before the current word completed.

Function
REQ-014 The block SHALL have two states: IDLE (no word in progress) and SHIFT (word in progress), plus an independent output holding register (DOUT/DVALID).
REQ-015 In IDLE, EN=1 & FRAME=1 SHALL capture IQZ as bit 0 of the word, set bit count to 1, and enter SHIFT; EN=1 & FRAME=0 SHALL discard IQZ and stay in IDLE.
REQ-016 In SHIFT, each EN=1 & FRAME=0 cycle SHALL capture IQZ into the next bit position and increment the bit count by 1.
REQ-017 EN=0 SHALL freeze the state, bit count, and shift register; FRAME and IQZ SHALL be ignored.
REQ-018 When the WIDTH-th bit is captured, the word SHALL be complete; the state SHALL return to IDLE on that same edge.
REQ-019 Latency: for a word whose last bit is sampled at edge k, DOUT/DVALID SHALL update at edge k (visible the following cycle).
REQ-020 Bit count SHALL never exceed WIDTH; it wraps to 0 on completion.
REQ-021 In SHIFT, EN=1 & FRAME=1 SHALL discard the partial word, set SYNC_ERR, and restart with IQZ as bit 0 (bit count = 1, state stays SHIFT).
REQ-022 With DVALID=0, a completed word SHALL load into DOUT and set DVALID=1.
REQ-023 DVALID=1 & DREADY=1 SHALL consume the word: DVALID clears at that edge unless a new word completes at the same edge.
REQ-024 If a word completes at the same edge as consumption, the new word SHALL load, DVALID SHALL stay 1, and OVF SHALL NOT set.
REQ-025 If a word completes while DVALID=1 & DREADY=0, the new word SHALL be dropped, DOUT SHALL retain the old word, and OVF SHALL set.
REQ-026 DOUT SHALL remain stable while DVALID=1 & DREADY=0.
REQ-027 ERR_CLR=1 SHALL clear OVF and SYNC_ERR at the edge; if a set condition occurs at the same edge, set SHALL win.
REQ-028 For WIDTH=2, FRAME on the cycle after the start bit SHALL be treated per REQ-021; completion SHALL take priority only when FRAME=0.

Reset
REQ-029 QRT=1 at a posedge of IQC SHALL force IDLE, bit count 0, shift register 0, DOUT=0, DVALID=0, OVF=0, and SYNC_ERR=0, overriding all other inputs.
REQ-030 QRT asserted mid-word SHALL discard the partial word; sampling SHALL resume only on a new FRAME after QRT is released.
REQ-031 QRT SHALL have no effect between clock edges; there is no asynchronous path.

Verification
REQ-032 WIDTH=8, MSB_FIRST=0, EN=1, DREADY=1, FRAME at bit 0, IQZ=1,0,1,1,0,0,1,0 -> DOUT=8'h4D and DVALID=1 for exactly one cycle after the 8th edge.
REQ-033 Same serial stream with MSB_FIRST=1 -> DOUT=8'hB2.
REQ-034 DREADY=0, two back-to-back words 8'hA5 then 8'h3C -> DOUT stays 8'hA5, DVALID=1, OVF=1; then pulse ERR_CLR -> OVF=0, DOUT still 8'hA5.
REQ-035 FRAME re-asserted after 3 bits, then a full word 8'hFF -> SYNC_ERR=1 and DOUT=8'hFF (no partial-word data).
REQ-036 EN toggled 0/1 every cycle during word 8'h5A -> DOUT=8'h5A after 8 enabled samples, and 16 edges total.
REQ-037 QRT pulsed after 4 bits, then a full word 8'h81 -> all outputs 0 during reset, then DOUT=8'h81 and OVF=SYNC_ERR=0.
